// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the 4-digit multiplexed display scan
// controller (seg_scan_ctrl) and its phase timer (scan_timer).
//   scan_state_t  : FSM state encoding (IDLE / BLANK / SHOW)
//   BCD_BLANK     : decoder code that turns every segment off
//   NUM_DIGITS    : number of digits sharing the decoder
//   cnt_width()   : phase counter width for a given DIV / BLANK_CYC pair
//   digit_nibble(): pick digit idx out of a packed 4-digit BCD word
//   lz_suppress() : leading-zero test for digit idx of a packed word
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

  localparam logic [3:0] BCD_BLANK  = 4'hF;
  localparam int         NUM_DIGITS = 4;

  // The counter has to reach max(div, blank_cyc)-1; div >= 2 keeps this >= 1.
  function automatic int cnt_width(input int div, input int blank_cyc);
    int m;
    m = (div > blank_cyc) ? div : blank_cyc;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

  function automatic logic [3:0] digit_nibble(input logic [15:0] value,
                                              input logic [1:0]  idx);
    logic [3:0] nib;
    case (idx)
      2'd0:    nib = value[3:0];
      2'd1:    nib = value[7:4];
      2'd2:    nib = value[11:8];
      default: nib = value[15:12];
    endcase
    return nib;
  endfunction

  // Digit idx is a leading zero when it and every more-significant digit
  // are zero. Digit 0 is never suppressed so a zero value still shows "0".
  function automatic logic lz_suppress(input logic [15:0] value,
                                       input logic [1:0]  idx);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(idx) && value[4*i +: 4] != 4'h0) begin
        upper_zero = 1'b0;
      end
    end
    return upper_zero && (idx != 2'd0);
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_scan_timer.sv
// scan_timer: phase counter for the display scan.
// Counts 0..LAST where LAST is DIV-1 (sel_show=1) or BLANK_CYC-1
// (sel_show=0), then wraps to 0 on the following edge.
// Ports:
//   clk      in  system clock, rising edge
//   rst      in  synchronous active-high reset (cnt -> 0)
//   clr      in  synchronous clear, holds cnt at 0 while high
//   sel_show in  1: terminal count DIV-1, 0: terminal count BLANK_CYC-1
//   cnt      out current phase count
//   tc       out high while cnt equals the selected terminal count
module scan_timer #(
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 500,
  parameter int CW        = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          sel_show,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  localparam logic [CW-1:0] SHOW_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  assign tc = (cnt == (sel_show ? SHOW_LAST : BLANK_LAST));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan of four common-cathode digits that
// share one BCD-to-7-segment decoder.
// Each frame is four (BLANK, SHOW) pairs, digit 0 first. The BCD word is
// snapshotted on the first cycle of a frame so a frame never tears.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   en         in   scan enable, 0 forces the display dark (IDLE)
//   lz_en      in   leading-zero suppression enable (live, not snapshotted)
//   digits     in   4-digit BCD value, [3:0] is digit 0
//   bcd        out  decoder input, 4'hF blanks the decoder
//   dig        out  one-hot digit enable, bit i drives digit i
//   frame_done out  one-cycle pulse on the last SHOW cycle of digit 3
// All outputs are registered from next-state values, so each output
// matches the state entered on the same edge and no input reaches an
// output combinationally.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        lz_en,
  input  logic [15:0] digits,
  output logic [3:0]  bcd,
  output logic [3:0]  dig,
  output logic        frame_done
);

  localparam int CW = cnt_width(DIV, BLANK_CYC);
  // SHOW is only ever entered at cnt=0 and DIV >= 2, so the last SHOW
  // cycle is always reached from a SHOW cycle with cnt = DIV-2.
  localparam logic [CW-1:0] SHOW_PRE_LAST = CW'(DIV - 2);

  scan_state_t   state, state_d;
  logic [1:0]    idx, idx_d;
  logic [15:0]   snap, snap_d;
  logic [CW-1:0] cnt;
  logic          tc;
  logic          snap_cycle;
  logic [3:0]    bcd_d;
  logic [3:0]    dig_d;
  logic          frame_done_d;

  // Phase counter: cleared while idle or being disabled, so every BLANK
  // entry from IDLE starts at cnt=0.
  scan_timer #(
    .DIV       (DIV),
    .BLANK_CYC (BLANK_CYC),
    .CW        (CW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (!en || state == ST_IDLE),
    .sel_show (state == ST_SHOW),
    .cnt      (cnt),
    .tc       (tc)
  );

  // First cycle of a frame; the only cycle on which digits is sampled.
  assign snap_cycle = (state == ST_BLANK) && (idx == 2'd0) && (cnt == '0);
  assign snap_d     = snap_cycle ? digits : snap;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_BLANK;
      idx   <= 2'd0;
      snap  <= 16'h0000;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      snap  <= snap_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    idx_d   = idx;
    if (!en) begin
      state_d = ST_IDLE;
      idx_d   = 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_d = ST_BLANK;
          idx_d   = 2'd0;
        end
        ST_BLANK: begin
          if (tc) begin
            state_d = ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (tc) begin
            state_d = ST_BLANK;
            idx_d   = idx + 2'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = 2'd0;
        end
      endcase
    end
  end

  // Output logic, evaluated on the state being entered. snap_d is used so
  // the first SHOW after a snapshot already sees the new value.
  always_comb begin
    dig_d        = 4'b0000;
    bcd_d        = BCD_BLANK;
    frame_done_d = en && (state == ST_SHOW) && (idx == 2'd3) &&
                   (cnt == SHOW_PRE_LAST);
    if (state_d == ST_SHOW) begin
      dig_d = 4'b0001 << idx_d;
      // A suppressed digit keeps dig asserted so duty stays constant.
      if (lz_en && lz_suppress(snap_d, idx_d)) begin
        bcd_d = BCD_BLANK;
      end else begin
        bcd_d = digit_nibble(snap_d, idx_d);
      end
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd        <= BCD_BLANK;
      dig        <= 4'b0000;
      frame_done <= 1'b0;
    end else begin
      bcd        <= bcd_d;
      dig        <= dig_d;
      frame_done <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: two scan controllers with different timing share the
// same stimulus. Expected outputs come from a frame-position model: each
// frame is a list of 4*(BLANK+DIV) slots, and the slot number alone gives
// which digit is lit and whether frame_done is due.
module tb_seg_scan_ctrl;

  localparam int D0 = 4;
  localparam int B0 = 1;
  localparam int D1 = 3;
  localparam int B1 = 3;

  // clock / reset / inputs
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        lz_en;
  logic [15:0] digits;

  logic [3:0]  bcd0, dig0, bcd1, dig1;
  logic        fd0, fd1;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DIV(D0), .BLANK_CYC(B0)) u_dut0 (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .lz_en      (lz_en),
    .digits     (digits),
    .bcd        (bcd0),
    .dig        (dig0),
    .frame_done (fd0)
  );

  seg_scan_ctrl #(.DIV(D1), .BLANK_CYC(B1)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .lz_en      (lz_en),
    .digits     (digits),
    .bcd        (bcd1),
    .dig        (dig1),
    .frame_done (fd1)
  );

  // reference model
  int          div_p [2] = '{D0, D1};
  int          blk_p [2] = '{B0, B1};
  bit          m_active [2];
  int          m_pos [2];
  logic [15:0] m_snap [2];

  // scoreboard: packed {frame_done, dig, bcd}
  logic [8:0]  exp_q [$];
  int          vectors     = 0;
  int          miscompares = 0;

  function automatic logic [8:0] model_out(input int k);
    int          seg, d, off, fl;
    logic [15:0] upper;
    logic [3:0]  nib;
    logic [3:0]  one_hot;
    logic        fd;
    if (!m_active[k]) return {1'b0, 4'b0000, 4'hF};
    seg   = blk_p[k] + div_p[k];
    fl    = 4 * seg;
    d     = m_pos[k] / seg;
    off   = m_pos[k] % seg;
    fd    = (m_pos[k] == fl - 1);
    if (off < blk_p[k]) return {fd, 4'b0000, 4'hF};
    upper   = m_snap[k] >> (4 * d);
    nib     = upper[3:0];
    one_hot = 4'(1 << d);
    if (lz_en && d != 0 && upper == 16'h0000) nib = 4'hF;
    return {fd, one_hot, nib};
  endfunction

  task automatic model_step(input int k);
    int fl;
    fl = 4 * (blk_p[k] + div_p[k]);
    if (rst) begin
      m_active[k] = 1'b1;
      m_pos[k]    = 0;
      m_snap[k]   = 16'h0000;
    end else begin
      if (m_active[k] && m_pos[k] == 0) m_snap[k] = digits;
      if (!en) begin
        m_active[k] = 1'b0;
      end else if (!m_active[k]) begin
        m_active[k] = 1'b1;
        m_pos[k]    = 0;
      end else begin
        m_pos[k] = (m_pos[k] + 1) % fl;
      end
    end
  endtask

  task automatic check_all();
    logic [8:0] exp;
    logic [8:0] obs;
    for (int k = 0; k < 2; k++) begin
      exp = exp_q.pop_front();
      obs = (k == 0) ? {fd0, dig0, bcd0} : {fd1, dig1, bcd1};
      vectors += 3;
      assert (obs[3:0] === exp[3:0]) else begin
        miscompares++;
        $error("FAIL bcd%0d t=%0t observed=%h expected=%h", k, $time, obs[3:0], exp[3:0]);
      end
      assert (obs[7:4] === exp[7:4]) else begin
        miscompares++;
        $error("FAIL dig%0d t=%0t observed=%b expected=%b", k, $time, obs[7:4], exp[7:4]);
      end
      assert (obs[8] === exp[8]) else begin
        miscompares++;
        $error("FAIL frame_done%0d t=%0t observed=%b expected=%b", k, $time, obs[8], exp[8]);
      end
    end
  endtask

  // driver: one clock, model update on the edge, check 1 ns later
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      model_step(k);
      exp_q.push_back(model_out(k));
    end
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // advance until dut0's model is at frame slot p (bounded)
  task automatic run_to_pos(input int p);
    int n;
    n = 0;
    while (!(m_active[0] && m_pos[0] == p) && n < 200) begin
      tick();
      n++;
    end
    vectors++;
    assert (n < 200) else begin
      miscompares++;
      $error("FAIL run_to_pos observed=timeout expected=slot %0d", p);
    end
  endtask

  initial begin
    rst    = 1'b1;
    en     = 1'b1;
    lz_en  = 1'b0;
    digits = 16'h1234;
    for (int k = 0; k < 2; k++) begin
      m_active[k] = 1'b1;
      m_pos[k]    = 0;
      m_snap[k]   = 16'h0000;
    end

    // reset held for 3 cycles
    run(3);

    // plain scan of 1234, change to 5678 during SHOW of digit 1
    rst = 1'b0;
    run(7);
    digits = 16'h5678;
    run(33);

    // leading-zero suppression
    lz_en  = 1'b1;
    digits = 16'h0070;
    run(45);
    digits = 16'h0000;
    run(45);
    lz_en  = 1'b0;
    run(25);

    // enable abort during SHOW of digit 2, then restart
    digits = 16'h4321;
    run_to_pos(12);
    en = 1'b0;
    run(4);
    en     = 1'b1;
    digits = 16'h9A0F;
    run(30);

    // reset landing on the last SHOW cycle of digit 3
    run_to_pos(18);
    rst = 1'b1;
    run(2);
    rst    = 1'b0;
    digits = 16'hBCDE;
    run(30);

    // en low straight out of reset
    rst = 1'b1;
    en  = 1'b0;
    run(2);
    rst = 1'b0;
    run(3);
    en = 1'b1;
    run(25);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      en  = ($urandom_range(0, 39) != 0);
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 49) == 0) lz_en = $urandom_range(0, 1);
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 3))
          0:       digits = 16'($urandom_range(0, 65535));
          1:       digits = 16'($urandom_range(0, 15));
          2:       digits = 16'($urandom_range(0, 255));
          default: digits = 16'h0000;
        endcase
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing scan controller that shares one BCD-to-7-segment decoder among four common-cathode digits. Each frame it snapshots a 4-digit BCD value and drives the shared decoder's BCD input and a one-hot digit-select bus, one digit at a time. A blanking gap between digits prevents ghosting. Optional leading-zero suppression is supported. It sits between the counter/arithmetic datapath and the board-level decoder and display pins.

## Interface
- `DIV`, 50000: clock cycles each digit is shown (SHOW phase); legal range ≥ 2.
- `BLANK_CYC`, 500: clock cycles of blanking before each digit; legal range ≥ 1.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  scan enable; 0 forces the display dark.
- `lz_en`  in  1  leading-zero suppression enable.
- `digits`  in  16  BCD value; [3:0] is digit 0 (least significant), [15:12] is digit 3.
- `bcd`  out  4  to shared decoder input; 4'hF means blank, and the decoder outputs all segments off for it.
- `dig`  out  4  one-hot digit enable, active-high; bit i selects digit i.
- `frame_done`  out  1  one-cycle pulse at the end of each frame.

## Operation
- FSM states: IDLE, BLANK, SHOW. Registers are `idx` (2-bit digit index), `cnt` (phase counter, width clog2(max(DIV,BLANK_CYC))), and `snap` (16-bit snapshot).
- IDLE: entered from any state on the cycle after `en`=0 is sampled. `idx`=0 and `cnt`=0.
- IDLE→BLANK when `en`=1. The BLANK entry always has `idx`=0 and `cnt`=0.
- BLANK: `cnt` counts 0..BLANK_CYC-1. When `cnt`=BLANK_CYC-1, go to SHOW and set `cnt`=0.
- SHOW: `cnt` counts 0..DIV-1. When `cnt`=DIV-1, go to BLANK, set `cnt`=0, and set `idx`=`idx`+1 (wraps 3→0).
- Snapshot: `snap`←`digits` on every cycle where state=BLANK, `idx`=0, `cnt`=0, i.e. the first cycle of each frame. Inputs are not sampled at any other time, so there is no tearing within a frame.
- Leading-zero suppression applies only when `lz_en`=1. Digit i is blank if `snap` digits i..3 are all 0 and i≠0. Digit 0 is never suppressed (0000 shows "0").
- `lz_en` is used combinationally against `snap` during SHOW. It is not snapshotted.
- Non-BCD nibbles (A–E) pass through unchanged; the decoder blanks them. Nibble F is also blank.
- `frame_done` pulses on the last SHOW cycle of `idx`=3.

## Timing
- All outputs are registered. Each output reflects the state entered on the same edge, with no combinational path from any input to any output.
- Reset values: state=BLANK, `idx`=0, `cnt`=0, `snap`=0, `bcd`=4'hF, `dig`=4'b0000, `frame_done`=0.
- The first cycle after reset release is a snapshot cycle if `en`=1. If `en`=0, the block goes to IDLE on the next edge.
- During BLANK and IDLE: `dig`=0 and `bcd`=4'hF.
- During SHOW: `dig`=1<<`idx`. `bcd`=`snap`[4·idx+3:4·idx], or 4'hF if the digit is suppressed. A suppressed digit still asserts `dig` (dark digit, constant duty).
- Frame length is 4·(BLANK_CYC+DIV) cycles. Input-to-display latency is at most one frame plus BLANK_CYC.
- `rst` mid-frame: return to reset values on the next edge, regardless of `en`.
- `en` falling mid-SHOW: the next cycle is IDLE with outputs dark. No `frame_done` is emitted for the aborted frame.
- `en` and `rst` both high: reset wins.

## Structure
- Shared package/header `seg_pkg` holds:
  - state encodings (IDLE, BLANK, SHOW);
  - `BCD_BLANK` = 4'hF;
  - `NUM_DIGITS` = 4.
- One sub-module, `scan_timer`, contains the phase counter. It takes a load/terminal-count select (DIV or BLANK_CYC) and outputs a `tc` (terminal count) flag. The FSM, snapshot, and suppression logic stay in the top module.
- The decoder is instantiated by the parent, not inside this block.

## Test plan
- Reset check: `rst`=1 for 3 cycles → `bcd`=F, `dig`=0000, `frame_done`=0. With DIV=4, BLANK_CYC=1, en=1, digits=16'h1234: `dig` sequence is 0000, 0001×4, 0000, 0010×4, … and `bcd` shows 4, 3, 2, 1. `frame_done` pulses at cycle 19; frame length is 20.
- Snapshot stability: change `digits` from 1234 to 5678 during SHOW of digit 1 → the rest of the frame still shows 2, 1. The next frame shows 8, 7, 6, 5.
- Leading-zero suppression: lz_en=1, digits=16'h0070 → digits 3 and 2 show `bcd`=F with `dig` asserted, digit 1 shows 7, digit 0 shows 0. With digits=16'h0000, only digit 0 shows 0.
- Enable abort: drop `en` during SHOW of digit 2 → next cycle `dig`=0000, `bcd`=F, with no `frame_done`. Re-raise `en` → restart at BLANK with `idx`=0 and a fresh snapshot.
- Mid-frame reset: assert `rst` on SHOW of digit 3's last cycle → no `frame_done`, all reset values on the next edge. After release, the scan restarts at digit 0.
